// File: rtl/cdc_pulse_data_tx.sv
// cdc_pulse_data_tx: source-side feeder for the cdc_pulse_data bridge.
// Buffers a valid/ready byte stream in a small FIFO and hands one word at a
// time to the bridge as a single-cycle out_vld pulse. It waits for the bridge
// to drop `active` before it issues the next word.
// Optional feature macro: CDC_PULSE_DATA_TX_STAT_EN adds the sent_cnt and
// drop_cnt statistics ports.
module cdc_pulse_data_tx #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          s_clk,
    input  logic          s_rstn,
    input  logic [DW-1:0] in_data,
    input  logic          in_vld,
    output logic          in_rdy,
    output logic [DW-1:0] out_din,
    output logic          out_vld,
    input  logic          active,
    output logic [AW:0]   level
`ifdef CDC_PULSE_DATA_TX_STAT_EN
    ,
    output logic [15:0]   sent_cnt,
    output logic [15:0]   drop_cnt
`endif
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     out_din_reg;
    logic              out_vld_reg;
    logic              push;
    logic              pop;

    // The pointers carry one extra wrap bit, so their difference is the occupancy 0..DEPTH.
    assign level   = wr_ptr_reg - rd_ptr_reg;
    // A push into a full FIFO is refused, even when a pop happens in the same cycle.
    assign in_rdy  = (level != FULL_LEVEL);
    assign push    = in_vld && in_rdy;
    assign out_din = out_din_reg;
    assign out_vld = out_vld_reg;

    // Next-state and pop decision: issue only from IDLE, with data present and the bridge quiet.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if ((level != '0) && !active) begin
                    pop        = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (!active) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FIFO storage. It has no reset, so it can map onto distributed or block RAM.
    always_ff @(posedge s_clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_data;
        end
    end

    // FIFO pointers. A reset discards every queued word.
    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Registered pulse toward the bridge. Data is forced to zero outside the pulse.
    // A pop needs level!=0 and a push needs level!=DEPTH, so the read and write
    // addresses always differ when both happen in one cycle.
    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            out_vld_reg <= 1'b0;
            out_din_reg <= '0;
        end else begin
            out_vld_reg <= pop;
            out_din_reg <= pop ? mem[rd_ptr_reg[AW-1:0]] : '0;
        end
    end

`ifdef CDC_PULSE_DATA_TX_STAT_EN
    logic [15:0] sent_cnt_reg;
    logic [15:0] drop_cnt_reg;

    assign sent_cnt = sent_cnt_reg;
    assign drop_cnt = drop_cnt_reg;

    // Statistics: sent count wraps; drop count (refused pushes) saturates.
    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            sent_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (pop) begin
                sent_cnt_reg <= sent_cnt_reg + 16'd1;
            end
            if (in_vld && !in_rdy && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdc_pulse_data_tx.sv
// Testbench for cdc_pulse_data_tx. A queue-based reference model predicts the
// outputs, and a simple bridge model drives `active`. When the design is built
// with CDC_PULSE_DATA_TX_STAT_EN, the bench also checks the statistics ports.
module tb_cdc_pulse_data_tx;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          s_clk = 1'b0;
    logic          s_rstn;
    logic [DW-1:0] in_data;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] out_din;
    logic          out_vld;
    logic          active;
    logic [2:0]    level;
`ifdef CDC_PULSE_DATA_TX_STAT_EN
    logic [15:0]   sent_cnt;
    logic [15:0]   drop_cnt;
`endif

    always #5 s_clk = ~s_clk;

    cdc_pulse_data_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
        .s_clk   (s_clk),
        .s_rstn  (s_rstn),
        .in_data (in_data),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .out_din (out_din),
        .out_vld (out_vld),
        .active  (active),
        .level   (level)
`ifdef CDC_PULSE_DATA_TX_STAT_EN
        ,
        .sent_cnt(sent_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: the words waiting at the source, plus a "word outstanding"
    // flag. The flag is set when a word is issued and cleared once the bridge is
    // seen idle at least two edges after the issue.
    byte unsigned mq[$];
    bit           m_wait;
    int           m_age;
    bit           m_vld;
    byte unsigned m_din;
    int           m_sent;
    int           m_drop;
    bit           pre_vld;

    // Bridge model: `active` rises on the edge that samples a pulse and stays
    // high for hold_len cycles.
    bit           bridge_mode;
    int           hold_len;
    int           act_cnt;

    int           pulse_cyc[$];
    byte unsigned pulse_dat[$];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wait  = 1'b0;
        m_age   = 0;
        m_vld   = 1'b0;
        m_din   = 8'h00;
        m_sent  = 0;
        m_drop  = 0;
        pre_vld = 1'b0;
        act_cnt = 0;
        active  = 1'b0;
    endtask

    task automatic model_edge();
        bit           issue;
        bit           full;
        byte unsigned popped;
        cyc++;
        pre_vld = m_vld;
        full    = (mq.size() == DEPTH);
        issue   = !m_wait && (mq.size() != 0) && !active;
        popped  = 8'h00;
        if (in_vld && full && m_drop != 16'hFFFF) m_drop++;
        if (issue) popped = mq.pop_front();
        if (in_vld && !full) mq.push_back(in_data);
        if (m_wait) begin
            m_age++;
            if (m_age >= 2 && !active) m_wait = 1'b0;
        end
        if (issue) begin
            m_wait = 1'b1;
            m_age  = 0;
            m_sent = (m_sent + 1) & 16'hFFFF;
        end
        m_vld = issue;
        m_din = issue ? popped : 8'h00;
    endtask

    task automatic compare();
        chk("out_vld", {31'b0, out_vld}, {31'b0, m_vld});
        chk("out_din", {24'b0, out_din}, {24'b0, m_din});
        chk("level",   {29'b0, level},   mq.size());
        chk("in_rdy",  {31'b0, in_rdy},  {31'b0, (mq.size() != DEPTH)});
        chk("vld_while_active", {31'b0, out_vld && active}, 32'd0);
`ifdef CDC_PULSE_DATA_TX_STAT_EN
        chk("sent_cnt", {16'b0, sent_cnt}, m_sent);
        chk("drop_cnt", {16'b0, drop_cnt}, m_drop);
`endif
        if (out_vld === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(out_din);
        end
    endtask

    // One clock cycle: drive the inputs, take the edge, check 1 ns later, then update the bridge.
    task automatic step(input bit v, input byte unsigned d);
        in_vld  = v;
        in_data = d;
        @(posedge s_clk);
        model_edge();
        #1;
        compare();
        if (bridge_mode) begin
            if (pre_vld) act_cnt = hold_len;
            else if (act_cnt > 0) act_cnt--;
            active = (act_cnt > 0);
        end
    endtask

    task automatic do_reset();
        in_vld  = 1'b0;
        in_data = 8'h00;
        s_rstn  = 1'b0;
        model_reset();
        #1;
        chk("rst_out_vld", {31'b0, out_vld}, 32'd0);
        chk("rst_level",   {29'b0, level},   32'd0);
        chk("rst_in_rdy",  {31'b0, in_rdy},  32'd1);
        compare();
        repeat (2) begin
            @(posedge s_clk);
            #1;
            compare();
        end
        s_rstn = 1'b1;
        pulse_cyc.delete();
        pulse_dat.delete();
    endtask

    initial begin
        s_rstn      = 1'b0;
        in_vld      = 1'b0;
        in_data     = 8'h00;
        bridge_mode = 1'b0;
        hold_len    = 0;
        model_reset();
        #1;
        do_reset();
        chk("rst_out_din", {24'b0, out_din}, 32'd0);

        // Single word with the bridge idle.
        bridge_mode = 1'b0;
        active      = 1'b0;
        step(1'b1, 8'hA5);
        chk("single_level1", {29'b0, level}, 32'd1);
        step(1'b0, 8'h00);
        chk("single_vld", {31'b0, out_vld}, 32'd1);
        chk("single_din", {24'b0, out_din}, 32'hA5);
        chk("single_level0", {29'b0, level}, 32'd0);
        step(1'b0, 8'h00);
        chk("single_vld_low", {31'b0, out_vld}, 32'd0);
        chk("single_din_zero", {24'b0, out_din}, 32'd0);
        repeat (3) step(1'b0, 8'h00);

        // Backpressure: the bridge stays busy for 20 cycles after each pulse.
        do_reset();
        bridge_mode = 1'b1;
        hold_len    = 20;
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        repeat (80) step(1'b0, 8'h00);
        chk("bp_count", pulse_dat.size(), 32'd3);
        if (pulse_dat.size() == 3) begin
            chk("bp_w0", pulse_dat[0], 32'h11);
            chk("bp_w1", pulse_dat[1], 32'h22);
            chk("bp_w2", pulse_dat[2], 32'h33);
            chk("bp_gap01", {31'b0, (pulse_cyc[1] - pulse_cyc[0]) >= 21}, 32'd1);
            chk("bp_gap12", {31'b0, (pulse_cyc[2] - pulse_cyc[1]) >= 21}, 32'd1);
        end

        // Full FIFO: six pushes while the bridge is held busy.
        do_reset();
        bridge_mode = 1'b0;
        active      = 1'b1;
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        chk("full_level", {29'b0, level}, 32'd4);
        chk("full_rdy", {31'b0, in_rdy}, 32'd0);
`ifdef CDC_PULSE_DATA_TX_STAT_EN
        chk("full_drop", {16'b0, drop_cnt}, 32'd2);
`endif
        active      = 1'b0;
        bridge_mode = 1'b1;
        hold_len    = 2;
        repeat (30) step(1'b0, 8'h00);
        chk("full_count", pulse_dat.size(), 32'd4);
        if (pulse_dat.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("full_order", pulse_dat[i], i + 1);
        end
`ifdef CDC_PULSE_DATA_TX_STAT_EN
        chk("full_sent", {16'b0, sent_cnt}, 32'd4);
`endif

        // Foreign activity: `active` is high while the FSM is idle with one word queued.
        do_reset();
        bridge_mode = 1'b0;
        active      = 1'b1;
        step(1'b1, 8'h5A);
        repeat (5) step(1'b0, 8'h00);
        chk("foreign_hold", pulse_dat.size(), 32'd0);
        active = 1'b0;
        step(1'b0, 8'h00);
        chk("foreign_vld", {31'b0, out_vld}, 32'd1);
        chk("foreign_din", {24'b0, out_din}, 32'h5A);
        repeat (3) step(1'b0, 8'h00);

        // Reset mid-operation: one word in flight and three words queued.
        do_reset();
        bridge_mode = 1'b1;
        hold_len    = 10;
        for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i));
        repeat (2) step(1'b0, 8'h00);
        chk("midrst_level", {29'b0, level}, 32'd3);
        do_reset();
        bridge_mode = 1'b1;
        hold_len    = 2;
        step(1'b1, 8'h77);
        repeat (6) step(1'b0, 8'h00);
        chk("midrst_count", pulse_dat.size(), 32'd1);
        if (pulse_dat.size() == 1) chk("midrst_word", pulse_dat[0], 32'h77);

        // Randomized traffic with a varying bridge round trip.
        do_reset();
        bridge_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            hold_len = $urandom_range(0, 6);
            step($urandom_range(0, 99) < 55, 8'($urandom));
        end
        hold_len = 1;
        repeat (40) step(1'b0, 8'h00);
        chk("rand_drained", {29'b0, level}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
